mousetrap_src_arbiter: RTL and testbench

//  Clocked front end for a mousetrap 2-phase bundled-data pipeline. Arbitrates (round-robin) among NREQ

---
 rtl/mousetrap_src_arbiter_pkg.sv | 34 +++
 rtl/mousetrap_src_arbiter_sync2.sv | 35 +++
 rtl/mousetrap_src_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mousetrap_src_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mousetrap_src_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mousetrap_src_arbiter_pkg                                         |
// | Brief  : Shared types and helpers for the mousetrap source arbiter: FSM    |
// |          state encoding and constant-evaluable clog2/max helpers.          |
// | Ports  : none (package)                                                    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package mousetrap_src_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SETUP    = 2'd1,
      ST_WAIT_ACK = 2'd2,
      ST_HALT     = 2'd3
   } state_e;

   // Number of bits needed to hold values 0..value-1 (0 for value <= 1).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage : mousetrap_src_arbiter_pkg
`default_nettype wire

// File: rtl/mousetrap_src_arbiter_sync2.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mousetrap_src_arbiter_sync2                                       |
// | Brief  : Two-flop synchronizer bringing an asynchronous level into clk.    |
// | Ports  : clk  - system clock                                               |
// |          rstn - asynchronous active-low reset (flops clear to 0)           |
// |          d_i  - asynchronous input level                                   |
// |          q_o  - synchronized level, two clocks of latency                  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module mousetrap_src_arbiter_sync2 (
   input  logic clk,
   input  logic rstn,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule : mousetrap_src_arbiter_sync2
`default_nettype wire

// File: rtl/mousetrap_src_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mousetrap_src_arbiter                                             |
// | Brief  : Clocked round-robin front end for a 2-phase bundled-data          |
// |          mousetrap pipeline. Grants one requester at a time, holds its     |
// |          data SETUP_CYC clocks, toggles reqN, waits for the synchronized   |
// |          ackNm1 to match, then pulses req_accept for that requester.       |
// | Ports  : clk, rstn (async active-low)                                      |
// |          req_valid/req_data  - NREQ requesters, data i at [i*WIDTH+:WIDTH] |
// |          req_accept          - one-hot 1-clk completion pulse              |
// |          reqN/datain         - 2-phase request and bundled data, stage 0   |
// |          ackNm1              - 2-phase ack from stage 0 (asynchronous)     |
// |          busy, grant_id, timeout_err (sticky until reset)                  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module mousetrap_src_arbiter
   import mousetrap_src_arbiter_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int NREQ      = 4,
   parameter int SETUP_CYC = 2,
   parameter int TIMEOUT   = 255
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*WIDTH-1:0]  req_data,
   output logic [NREQ-1:0]        req_accept,
   output logic                   reqN,
   output logic [WIDTH-1:0]       datain,
   input  logic                   ackNm1,
   output logic                   busy,
   output logic [clog2(NREQ)-1:0] grant_id,
   output logic                   timeout_err
);

   localparam int C_GW    = clog2(NREQ);
   // One counter serves both the setup hold and the ack timeout.
   localparam int C_CNT_W = clog2(max2(SETUP_CYC, TIMEOUT) + 1);
   localparam logic [C_CNT_W-1:0] C_SETUP_LOAD   = C_CNT_W'(SETUP_CYC - 1);
   localparam logic [C_CNT_W-1:0] C_TIMEOUT_LAST = C_CNT_W'(TIMEOUT - 1);
   localparam logic [C_GW-1:0]    C_LAST_IDX     = C_GW'(NREQ - 1);

   state_e               state_q, state_d;
   logic [C_GW-1:0]      rr_q, rr_d;
   logic [C_GW-1:0]      gid_q, gid_d;
   logic [WIDTH-1:0]     data_q, data_d;
   logic [C_CNT_W-1:0]   cnt_q, cnt_d;
   logic                 reqn_q, reqn_d;
   logic [NREQ-1:0]      acc_q, acc_d;
   logic                 terr_q, terr_d;

   logic                 w_ack_s;
   logic                 w_pick_valid;
   logic [C_GW-1:0]      w_pick_idx;
   logic [C_GW-1:0]      w_cand;
   logic [WIDTH-1:0]     w_data [NREQ];

   mousetrap_src_arbiter_sync2 u_ack_sync (
      .clk  (clk),
      .rstn (rstn),
      .d_i  (ackNm1),
      .q_o  (w_ack_s)
   );

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_data[gi] = req_data[gi*WIDTH +: WIDTH];
   end

   // Round-robin pick: scan offsets from the highest down so the lowest
   // offset from rr_q that is valid is the one left standing.
   always_comb begin
      w_pick_valid = 1'b0;
      w_pick_idx   = rr_q;
      w_cand       = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_cand = C_GW'((int'(rr_q) + k) % NREQ);
         if (req_valid[w_cand]) begin
            w_pick_valid = 1'b1;
            w_pick_idx   = w_cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      gid_d   = gid_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      reqn_d  = reqn_q;
      acc_d   = '0;
      terr_d  = terr_q;
      case (state_q)
         ST_IDLE: begin
            // datain only ever changes here, so it cannot move while a
            // token is in flight.
            if (w_pick_valid) begin
               gid_d   = w_pick_idx;
               data_d  = w_data[w_pick_idx];
               cnt_d   = C_SETUP_LOAD;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (cnt_q == '0) begin
               reqn_d  = ~reqn_q;
               cnt_d   = '0;
               state_d = ST_WAIT_ACK;
            end else begin
               cnt_d = cnt_q - C_CNT_W'(1);
            end
         end
         ST_WAIT_ACK: begin
            if (w_ack_s == reqn_q) begin
               acc_d[gid_q] = 1'b1;
               rr_d         = (gid_q == C_LAST_IDX) ? '0 : gid_q + C_GW'(1);
               state_d      = ST_IDLE;
            end else if (TIMEOUT > 0) begin
               if (cnt_q == C_TIMEOUT_LAST) begin
                  terr_d  = 1'b1;
                  state_d = ST_HALT;
               end else begin
                  cnt_d = cnt_q + C_CNT_W'(1);
               end
            end
         end
         ST_HALT: begin
            // Terminal: everything frozen until rstn.
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         rr_q    <= '0;
         gid_q   <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         reqn_q  <= 1'b0;
         acc_q   <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         gid_q   <= gid_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         reqn_q  <= reqn_d;
         acc_q   <= acc_d;
         terr_q  <= terr_d;
      end
   end

   assign req_accept  = acc_q;
   assign reqN        = reqn_q;
   assign datain      = data_q;
   assign busy        = (state_q != ST_IDLE);
   assign grant_id    = gid_q;
   assign timeout_err = terr_q;

endmodule : mousetrap_src_arbiter
`default_nettype wire

// File: tb/tb_mousetrap_src_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_mousetrap_src_arbiter                                          |
// | Brief  : Self-checking bench: stage-0 element model with random ack delay, |
// |          round-robin reference model, directed and random token sequences. |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_mousetrap_src_arbiter;

   localparam int WIDTH     = 8;
   localparam int NREQ      = 4;
   localparam int SETUP_CYC = 3;
   localparam int TIMEOUT   = 10;

   logic                  clk;
   logic                  rstn;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_accept;
   logic                  reqN;
   logic [WIDTH-1:0]      datain;
   logic                  ackNm1;
   logic                  busy;
   logic [1:0]            grant_id;
   logic                  timeout_err;

   logic ack_model;
   logic ack_spur;
   logic stall;

   int   errors;
   int   checks;
   int   rr_ptr;   // reference round-robin pointer
   logic pol;      // reference reqN level

   assign ackNm1 = ack_model ^ ack_spur;

   mousetrap_src_arbiter #(
      .WIDTH     (WIDTH),
      .NREQ      (NREQ),
      .SETUP_CYC (SETUP_CYC),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_accept  (req_accept),
      .reqN        (reqN),
      .datain      (datain),
      .ackNm1      (ackNm1),
      .busy        (busy),
      .grant_id    (grant_id),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stage-0 element: done follows reqN after a random 1-20 ns latch delay.
   initial begin
      int unsigned d;
      ack_model = 1'b0;
      forever begin
         @(reqN or negedge rstn);
         if (!rstn) begin
            ack_model = 1'b0;
         end else if (!stall) begin
            d = $urandom_range(1, 20);
            #(d);
            if (!rstn)       ack_model = 1'b0;
            else if (!stall) ack_model = reqN;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (((v >> ((p + k) % NREQ)) & 1) != 0) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [WIDTH-1:0] get_data(input int i);
      return WIDTH'(req_data >> (i * WIDTH));
   endfunction

   task automatic set_data(input int i, input logic [WIDTH-1:0] v);
      req_data[i*WIDTH +: WIDTH] = v;
   endtask

   task automatic set_valid(input int i, input bit on);
      if (on) req_valid = req_valid | (NREQ'(1) << i);
      else    req_valid = req_valid & ~(NREQ'(1) << i);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_reqN"},        32'(reqN),        32'd0);
      chk({tag, "_datain"},      32'(datain),      32'd0);
      chk({tag, "_req_accept"},  32'(req_accept),  32'd0);
      chk({tag, "_busy"},        32'(busy),        32'd0);
      chk({tag, "_grant_id"},    32'(grant_id),    32'd0);
      chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
   endtask

   // One complete token. Valids may only be changed at the accept sample
   // (IDLE), so the reference pick taken at entry matches the grant edge.
   task automatic run_token(input bit drop_mid, input bit refill,
                            input logic [NREQ-1:0] add_mask, input string tag);
      int               g;
      int               n;
      logic [WIDTH-1:0] ed;
      g  = pick(req_valid, rr_ptr);
      ed = get_data(g);
      n  = 0;
      while (busy !== 1'b1 && n < 20) begin tick(); n++; end
      chk({tag, "_grant_seen"}, 32'(busy),     32'd1);
      chk({tag, "_grant_id"},   32'(grant_id), 32'(g));
      chk({tag, "_datain"},     32'(datain),   32'(ed));
      chk({tag, "_reqN_pre"},   32'(reqN),     32'(pol));
      for (int c = 1; c < SETUP_CYC; c++) begin
         tick();
         chk({tag, "_setup_reqN"}, 32'(reqN),   32'(pol));
         chk({tag, "_setup_data"}, 32'(datain), 32'(ed));
      end
      tick();
      pol = ~pol;
      chk({tag, "_reqN_toggle"}, 32'(reqN),   32'(pol));
      chk({tag, "_bundle_data"}, 32'(datain), 32'(ed));
      if (drop_mid) set_valid(g, 1'b0);
      n = 0;
      while (req_accept === '0 && n < 30) begin
         chk({tag, "_hold_data"}, 32'(datain), 32'(ed));
         tick();
         n++;
      end
      chk({tag, "_accept"},      32'(req_accept), 32'(1 << g));
      chk({tag, "_accept_idle"}, 32'(busy),       32'd0);
      chk({tag, "_reqN_level"},  32'(reqN),       32'(pol));
      rr_ptr = (g + 1) % NREQ;
      if (refill) set_data(g, WIDTH'($urandom));
      else        set_valid(g, 1'b0);
      for (int i = 0; i < NREQ; i++) begin
         if (((add_mask >> i) & 1) != 0 && ((req_valid >> i) & 1) == 0) begin
            set_data(i, WIDTH'($urandom));
            set_valid(i, 1'b1);
         end
      end
      tick();
      chk({tag, "_accept_pulse"}, 32'(req_accept), 32'd0);
   endtask

   initial begin
      int n;
      errors    = 0;
      checks    = 0;
      rr_ptr    = 0;
      pol       = 1'b0;
      rstn      = 1'b0;
      req_valid = '0;
      req_data  = '0;
      ack_spur  = 1'b0;
      stall     = 1'b0;

      // Power-on reset
      repeat (3) tick();
      chk_reset("por");
      rstn = 1'b1;
      repeat (2) tick();
      chk("por_release_busy", 32'(busy), 32'd0);

      // Single token from requester 2
      set_data(2, 8'hA5);
      set_valid(2, 1'b1);
      run_token(1'b0, 1'b0, '0, "single");
      chk("single_grant_id", 32'(grant_id), 32'd2);
      chk("single_datain",   32'(datain),   32'hA5);

      // All requesters held valid: strict rotation
      for (int i = 0; i < NREQ; i++) set_data(i, WIDTH'($urandom));
      req_valid = '1;
      for (int t = 0; t < 8; t++) run_token(1'b0, 1'b1, '0, "rr");

      // Random traffic
      for (int t = 0; t < 16; t++)
         run_token(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   NREQ'($urandom_range(1, 15)), "rand");
      n = 0;
      while (req_valid != '0 && n < 10) begin
         run_token(1'b0, 1'b0, '0, "drain");
         n++;
      end
      chk("drain_empty", 32'(req_valid), 32'd0);

      // Spurious ack toggles in IDLE
      repeat (3) tick();
      chk("idle_busy", 32'(busy), 32'd0);
      ack_spur = 1'b1;
      repeat (4) begin
         tick();
         chk("spur_busy",   32'(busy),       32'd0);
         chk("spur_accept", 32'(req_accept), 32'd0);
         chk("spur_reqN",   32'(reqN),       32'(pol));
      end
      ack_spur = 1'b0;
      repeat (4) tick();

      // req_valid dropped mid-token
      set_data(0, WIDTH'($urandom));
      set_valid(0, 1'b1);
      run_token(1'b1, 1'b0, '0, "drop");

      // Asynchronous reset in the middle of WAIT_ACK
      stall = 1'b1;
      set_data(1, 8'h3C);
      set_valid(1, 1'b1);
      n = 0;
      while (busy !== 1'b1 && n < 20) begin tick(); n++; end
      chk("mid_grant_seen", 32'(busy), 32'd1);
      repeat (SETUP_CYC + 2) tick();
      pol = ~pol;
      chk("mid_wait_reqN", 32'(reqN), 32'(pol));
      chk("mid_wait_busy", 32'(busy), 32'd1);
      #2;
      rstn = 1'b0;
      #1;
      chk_reset("async");
      req_valid = '0;
      tick();
      rstn   = 1'b1;
      rr_ptr = 0;
      pol    = 1'b0;
      repeat (2) tick();
      chk("async_rel_busy", 32'(busy), 32'd0);
      chk("async_rel_reqN", 32'(reqN), 32'd0);

      // Ack stuck: timeout into HALT
      set_data(3, 8'h5A);
      set_valid(3, 1'b1);
      n = 0;
      while (busy !== 1'b1 && n < 20) begin tick(); n++; end
      chk("to_grant_id", 32'(grant_id), 32'd3);
      repeat (SETUP_CYC) tick();
      chk("to_reqN", 32'(reqN), 32'd1);
      for (int j = 1; j < TIMEOUT; j++) begin
         tick();
         chk("to_pre", 32'(timeout_err), 32'd0);
      end
      tick();
      chk("to_err",  32'(timeout_err), 32'd1);
      chk("to_busy", 32'(busy),        32'd1);
      ack_spur = 1'b1;   // late matching ack must not revive the token
      set_data(0, 8'h77);
      set_valid(0, 1'b1);
      repeat (8) begin
         tick();
         chk("halt_accept", 32'(req_accept),  32'd0);
         chk("halt_reqN",   32'(reqN),        32'd1);
         chk("halt_gid",    32'(grant_id),    32'd3);
         chk("halt_data",   32'(datain),      32'h5A);
         chk("halt_sticky", 32'(timeout_err), 32'd1);
      end
      #2;
      rstn = 1'b0;
      #1;
      chk_reset("halt_rst");
      ack_spur  = 1'b0;
      req_valid = '0;
      stall     = 1'b0;
      tick();
      rstn = 1'b1;
      repeat (2) tick();
      chk("halt_rel_err",  32'(timeout_err), 32'd0);
      chk("halt_rel_busy", 32'(busy),        32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_mousetrap_src_arbiter
`default_nettype wire
